// File: rtl/pipe_stage_reg.sv
// Generic Y86-64 pipeline-stage register with stall hold, bubble (nop) injection and sync reset.
// Define PIPE_STAGE_PERF_EN to build the saturating load/stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int               WORD_W       = 64,
  parameter int               STAT_W       = 2,
  parameter logic [3:0]       BUBBLE_ICODE = 4'h1,
  parameter logic [STAT_W-1:0] BUBBLE_STAT = '0,
  parameter logic [3:0]       REG_NONE     = 4'hF,
  parameter int               CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [STAT_W-1:0] in_stat,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [3:0]        in_dstE,
  input  logic [3:0]        in_dstM,
  input  logic [WORD_W-1:0] in_valC,
  input  logic [WORD_W-1:0] in_valA,
  input  logic [WORD_W-1:0] in_valB,
  output logic              out_valid,
  output logic [STAT_W-1:0] out_stat,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_ifun,
  output logic [3:0]        out_rA,
  output logic [3:0]        out_rB,
  output logic [3:0]        out_dstE,
  output logic [3:0]        out_dstM,
  output logic [WORD_W-1:0] out_valC,
  output logic [WORD_W-1:0] out_valA,
  output logic [WORD_W-1:0] out_valB,
  output logic [CNT_W-1:0]  perf_loads,
  output logic [CNT_W-1:0]  perf_stalls,
  output logic [CNT_W-1:0]  perf_bubbles
);

  logic load_bubble;
  logic load_in;

  // Reset and bubble share the nop bundle; bubble beats stall, so a held bundle is discarded.
  assign load_bubble = reset | bubble;
  assign load_in     = ~reset & ~bubble & ~stall;

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      out_valid <= 1'b0;
      out_stat  <= BUBBLE_STAT;
      out_icode <= BUBBLE_ICODE;
      out_ifun  <= 4'h0;
      out_rA    <= REG_NONE;
      out_rB    <= REG_NONE;
      out_dstE  <= REG_NONE;
      out_dstM  <= REG_NONE;
      out_valC  <= '0;
      out_valA  <= '0;
      out_valB  <= '0;
    end else if (load_in) begin
      out_valid <= in_valid;
      out_stat  <= in_stat;
      out_icode <= in_icode;
      out_ifun  <= in_ifun;
      out_rA    <= in_rA;
      out_rB    <= in_rB;
      out_dstE  <= in_dstE;
      out_dstM  <= in_dstM;
      out_valC  <= in_valC;
      out_valA  <= in_valA;
      out_valB  <= in_valB;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] loads_q;
  logic [CNT_W-1:0] stalls_q;
  logic [CNT_W-1:0] bubbles_q;
  logic             stall_only;

  assign stall_only = ~reset & ~bubble & stall;

  // Each counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      loads_q   <= '0;
      stalls_q  <= '0;
      bubbles_q <= '0;
    end else begin
      if (load_in && in_valid && (loads_q != '1))
        loads_q <= loads_q + CNT_ONE;
      if (stall_only && (stalls_q != '1))
        stalls_q <= stalls_q + CNT_ONE;
      if (bubble && (bubbles_q != '1))
        bubbles_q <= bubbles_q + CNT_ONE;
    end
  end

  assign perf_loads   = loads_q;
  assign perf_stalls  = stalls_q;
  assign perf_bubbles = bubbles_q;
`else
  assign perf_loads   = '0;
  assign perf_stalls  = '0;
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vectors plus a bundle-level reference model.
// Counter expectations follow PIPE_STAGE_PERF_EN (zero when it is undefined).
module tb_pipe_stage_reg;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [63:0] valc;
    logic [63:0] vala;
    logic [63:0] valb;
  } bundle_t;

  localparam bundle_t NOP = '{valid: 1'b0, stat: 2'd0, icode: 4'h1, ifun: 4'h0,
                              ra: 4'hF, rb: 4'hF, dste: 4'hF, dstm: 4'hF,
                              valc: 64'd0, vala: 64'd0, valb: 64'd0};

  logic clk = 1'b0;
  logic reset, stall, bubble;
  bundle_t drive;
  logic out_valid;
  logic [1:0] out_stat;
  logic [3:0] out_icode, out_ifun, out_rA, out_rB, out_dstE, out_dstM;
  logic [63:0] out_valC, out_valA, out_valB;
  logic [CNT_W-1:0] perf_loads, perf_stalls, perf_bubbles;

  int n_checks = 0;
  int n_pass = 0;

  pipe_stage_reg #(.WORD_W(64), .STAT_W(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .bubble(bubble),
    .in_valid(drive.valid), .in_stat(drive.stat), .in_icode(drive.icode),
    .in_ifun(drive.ifun), .in_rA(drive.ra), .in_rB(drive.rb),
    .in_dstE(drive.dste), .in_dstM(drive.dstm),
    .in_valC(drive.valc), .in_valA(drive.vala), .in_valB(drive.valb),
    .out_valid(out_valid), .out_stat(out_stat), .out_icode(out_icode),
    .out_ifun(out_ifun), .out_rA(out_rA), .out_rB(out_rB),
    .out_dstE(out_dstE), .out_dstM(out_dstM),
    .out_valC(out_valC), .out_valA(out_valA), .out_valB(out_valB),
    .perf_loads(perf_loads), .perf_stalls(perf_stalls), .perf_bubbles(perf_bubbles)
  );

  always #5 clk = ~clk;

  // Reference model: what the stage must hold after each edge, plus ideal saturating counts.
  bundle_t m_out;
  int m_loads, m_stalls, m_bubbles;
  bit model_ok = 1'b0;
  bit done = 1'b0;

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_out = NOP;
      m_loads = 0; m_stalls = 0; m_bubbles = 0;
      model_ok = 1'b1;
    end else if (bubble) begin
      m_out = NOP;
      m_bubbles = sat_inc(m_bubbles);
    end else if (stall) begin
      m_stalls = sat_inc(m_stalls);
    end else begin
      m_out = drive;
      if (drive.valid) m_loads = sat_inc(m_loads);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Every cycle after the first reset, the whole bundle and the counters must match the model.
  always @(negedge clk) begin
    if (model_ok && !done) begin
      bundle_t act;
      act = '{out_valid, out_stat, out_icode, out_ifun, out_rA, out_rB,
              out_dstE, out_dstM, out_valC, out_valA, out_valB};
      n_checks++;
      if (act === m_out) n_pass++;
      else $display("[TB] FAIL bundle @%0t: got %h, expected %h", $time, act, m_out);
      checkOutput("perf_loads",   64'(perf_loads),   PERF_ON ? 64'(m_loads)   : 64'd0);
      checkOutput("perf_stalls",  64'(perf_stalls),  PERF_ON ? 64'(m_stalls)  : 64'd0);
      checkOutput("perf_bubbles", 64'(perf_bubbles), PERF_ON ? 64'(m_bubbles) : 64'd0);
    end
  end

  function automatic bundle_t mk(input logic v, input logic [3:0] icode, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic [63:0] valc,
                                 input logic [63:0] vala, input logic [63:0] valb);
    bundle_t b;
    b = '{valid: v, stat: 2'd0, icode: icode, ifun: 4'h0, ra: ra, rb: rb,
          dste: rb, dstm: 4'hF, valc: valc, vala: vala, valb: valb};
    return b;
  endfunction

  function automatic bundle_t rnd_bundle();
    bundle_t b;
    b.valid = 1'($urandom);
    b.stat  = 2'($urandom);
    b.icode = 4'($urandom); b.ifun = 4'($urandom);
    b.ra = 4'($urandom); b.rb = 4'($urandom);
    b.dste = 4'($urandom); b.dstm = 4'($urandom);
    b.valc = {$urandom, $urandom}; b.vala = {$urandom, $urandom}; b.valb = {$urandom, $urandom};
    return b;
  endfunction

  task automatic applyStimulus(input logic r, input logic s, input logic b, input bundle_t bd);
    reset = r; stall = s; bubble = b; drive = bd;
    @(posedge clk);
    #1;
  endtask

  bundle_t bd;

  initial begin
    reset = 1'b1; stall = 1'b0; bubble = 1'b0; drive = rnd_bundle();

    // Reset for two edges with garbage inputs.
    applyStimulus(1, 0, 0, rnd_bundle());
    applyStimulus(1, $urandom_range(0,1) == 1, 0, rnd_bundle());
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_icode", 64'(out_icode), 64'h1);
    checkOutput("reset_dstE",  64'(out_dstE),  64'hF);
    checkOutput("reset_valA",  out_valA,       64'd0);
    checkOutput("reset_loads", 64'(perf_loads), 64'd0);

    // Plain load, one-edge latency.
    applyStimulus(0, 0, 0, mk(1, 4'h6, 4'h2, 4'h3, 64'd0, 64'h5, 64'h7));
    checkOutput("load_icode", 64'(out_icode), 64'h6);
    checkOutput("load_rA",    64'(out_rA),    64'h2);
    checkOutput("load_rB",    64'(out_rB),    64'h3);
    checkOutput("load_valA",  out_valA,       64'h5);
    checkOutput("load_valB",  out_valB,       64'h7);
    checkOutput("load_valid", 64'(out_valid), 64'd1);
    checkOutput("load_perf",  64'(perf_loads), PERF_ON ? 64'd1 : 64'd0);

    // Stall holds DEAD while the input shows BEEF.
    applyStimulus(0, 0, 0, mk(1, 4'h3, 4'h1, 4'h2, 64'hDEAD, 64'h0, 64'h0));
    repeat (3) applyStimulus(0, 1, 0, mk(1, 4'h3, 4'h1, 4'h2, 64'hBEEF, 64'h0, 64'h0));
    checkOutput("stall_valC",  out_valC, 64'hDEAD);
    checkOutput("stall_count", 64'(perf_stalls), PERF_ON ? 64'd3 : 64'd0);
    applyStimulus(0, 0, 0, mk(1, 4'h3, 4'h1, 4'h2, 64'hBEEF, 64'h0, 64'h0));
    checkOutput("release_valC", out_valC, 64'hBEEF);

    // Stall and bubble together: bubble wins, no stall count.
    bd = mk(1, 4'h5, 4'h4, 4'h5, 64'h11, 64'h22, 64'h33);
    applyStimulus(0, 1, 1, bd);
    checkOutput("sb_icode",   64'(out_icode), 64'h1);
    checkOutput("sb_dstM",    64'(out_dstM),  64'hF);
    checkOutput("sb_valid",   64'(out_valid), 64'd0);
    checkOutput("sb_bubbles", 64'(perf_bubbles), PERF_ON ? 64'd1 : 64'd0);
    checkOutput("sb_stalls",  64'(perf_stalls),  PERF_ON ? 64'd3 : 64'd0);

    // Reset during a stall, then a normal load.
    applyStimulus(0, 0, 0, mk(1, 4'h2, 4'h6, 4'h7, 64'h99, 64'h1, 64'h2));
    applyStimulus(0, 1, 0, mk(1, 4'h8, 4'h6, 4'h7, 64'h99, 64'h1, 64'h2));
    applyStimulus(1, 1, 0, mk(1, 4'h8, 4'h6, 4'h7, 64'h99, 64'h1, 64'h2));
    checkOutput("rst_stall_icode", 64'(out_icode), 64'h1);
    checkOutput("rst_stall_cnt",   64'(perf_stalls), 64'd0);
    applyStimulus(0, 0, 0, mk(1, 4'h7, 4'h0, 4'h1, 64'h42, 64'h43, 64'h44));
    checkOutput("after_rst_icode", 64'(out_icode), 64'h7);
    checkOutput("after_rst_loads", 64'(perf_loads), PERF_ON ? 64'd1 : 64'd0);

    // Bubble right after a stall discards the held bundle; invalid load is not counted.
    applyStimulus(0, 1, 0, mk(1, 4'h9, 4'h0, 4'h1, 64'h0, 64'h0, 64'h0));
    applyStimulus(0, 0, 1, mk(1, 4'h9, 4'h0, 4'h1, 64'h0, 64'h0, 64'h0));
    checkOutput("stall_bubble_valC", out_valC, 64'd0);
    applyStimulus(0, 0, 0, mk(0, 4'hA, 4'h3, 4'h4, 64'h5, 64'h6, 64'h7));
    checkOutput("inval_valid", 64'(out_valid), 64'd0);
    checkOutput("inval_icode", 64'(out_icode), 64'hA);
    checkOutput("inval_loads", 64'(perf_loads), PERF_ON ? 64'd1 : 64'd0);

    // Bit-exact data: no extension of top bits.
    bd = '{valid: 1'b1, stat: 2'd3, icode: 4'hC, ifun: 4'hE, ra: 4'h0, rb: 4'hF,
           dste: 4'h5, dstm: 4'hA, valc: 64'hFFFF_FFFF_FFFF_FFFF,
           vala: 64'h8000_0000_0000_0001, valb: 64'h0000_0000_8000_0000};
    applyStimulus(0, 0, 0, bd);
    checkOutput("exact_valA", out_valA, 64'h8000_0000_0000_0001);
    checkOutput("exact_stat", 64'(out_stat), 64'd3);

    // Saturation: 20 consecutive stalls after a reset.
    applyStimulus(1, 0, 1, rnd_bundle());
    checkOutput("rst_bubble_cnt", 64'(perf_bubbles), 64'd0);
    repeat (20) applyStimulus(0, 1, 0, rnd_bundle());
    checkOutput("sat_stalls", 64'(perf_stalls), PERF_ON ? 64'hF : 64'd0);
    checkOutput("sat_held_icode", 64'(out_icode), 64'h1);

    // Random control mix, checked against the model each cycle.
    for (int i = 0; i < 60; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) == 0, rnd_bundle());
    end
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, $urandom_range(0, 1) == 1, rnd_bundle());
    end

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic Y86-64 pipeline-stage register, generalising the execute-stage latch.
- Sits between any two stages (F/D, D/E, E/M, M/W).
- Captures the full instruction bundle each cycle, with stall (hold), bubble (inject nop) and synchronous reset.
- Provides an out_valid flag and optional saturating per-stage performance counters for hazard analysis.

Parameters:
- WORD_W, 64, width of valC/valA/valB.
- STAT_W, 2, width of stat field.
- BUBBLE_ICODE, 4'h1, icode loaded on bubble/reset (nop).
- BUBBLE_STAT, 0, stat loaded on bubble/reset (AOK encoding).
- REG_NONE, 4'hF, register ID loaded into rA/rB/dstE/dstM on bubble/reset.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold current contents
- bubble  in  1  load nop bundle
- in_valid  in  1  upstream bundle is a real instruction
- in_stat  in  STAT_W  upstream status
- in_icode, in_ifun, in_rA, in_rB, in_dstE, in_dstM  in  4 each  upstream fields
- in_valC, in_valA, in_valB  in  WORD_W each  upstream data
- out_valid  out  1  registered bundle is a real instruction
- out_stat  out  STAT_W
- out_icode, out_ifun, out_rA, out_rB, out_dstE, out_dstM  out  4 each
- out_valC, out_valA, out_valB  out  WORD_W each
- perf_loads, perf_stalls, perf_bubbles  out  CNT_W each  counters (optional feature)

Behaviour:
- All outputs are registered; updates occur only on rising clk.
- Reset/bubble bundle: out_valid=0, out_stat=BUBBLE_STAT, out_icode=BUBBLE_ICODE, out_ifun=0, out_rA=out_rB=out_dstE=out_dstM=REG_NONE, out_valC=out_valA=out_valB=0.
- Priority per edge, highest first:
  1. reset: load bubble bundle; clear all counters.
  2. bubble: load bubble bundle. Bubble overrides stall when both are asserted; the stall counter does not increment.
  3. stall: hold every output unchanged, including out_valid.
  4. otherwise, load: out_* <= in_*, out_valid <= in_valid.
- Latency: 1 cycle from in_* to out_* when loading.
- Held contents under stall persist for any number of cycles; in_* changes during stall are ignored.
- A bubble on the cycle after a stall discards the held bundle.
- Reset asserted mid-stall or mid-bubble sequence: reset wins on that edge; the next non-reset edge follows normal priority.
- No X on outputs after the first reset edge.
- Width rules: data fields are copied bit-exact; no sign or zero extension inside the block.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - perf_loads increments on each load edge with in_valid=1.
  - perf_stalls increments on each stall-only edge.
  - perf_bubbles increments on each bubble edge (not reset).
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - All counters clear on reset.
- Undefined: perf_* ports remain, tied to 0; no counter flops are synthesised.

Test Plan:
- Reset: hold reset=1 for 2 cycles with random in_* -> out_valid=0, out_icode=4'h1, out_dstE=4'hF, out_valA=0, counters=0.
- Load: in_icode=4'h6, in_ifun=4'h0, in_rA=4'h2, in_rB=4'h3, in_valA=64'h5, in_valB=64'h7, in_valid=1, no stall/bubble -> identical values on out_* one edge later, out_valid=1, perf_loads=1.
- Stall hold: load in_valC=64'hDEAD, then stall=1 for 3 edges while in_valC=64'hBEEF -> out_valC stays 64'hDEAD, perf_stalls=3; release -> out_valC=64'hBEEF next edge.
- Stall+bubble together: stall=1, bubble=1 on one edge with in_icode=4'h5 -> out_icode=4'h1, out_dstM=4'hF, out_valid=0, perf_bubbles=1, perf_stalls unchanged.
- Reset mid-stall: stall=1 and reset=1 on the same edge -> bubble bundle loaded, counters=0; next edge with no controls loads in_*.
- Saturation (CNT_W=4, macro defined): 20 consecutive stall edges -> perf_stalls=4'hF. Same test without the macro -> perf_stalls=0 throughout.
